// File: rtl/bvh_prim_fetch_arbiter.sv
// Round-robin arbiter sharing one single-port primitive RAM (1-cycle read latency) among
// NUM_REQ ray-traversal requesters; one fetch in flight, response held until accepted.
//
// state       | meaning
// ST_IDLE     | waiting for a request; grant and RAM read issue happen combinationally here
// ST_READ     | RAM data returning; capture response data and error flag
// ST_RESPOND  | response held on the bus until the granted requester accepts it
module bvh_prim_fetch_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int PRIM_WIDTH = 256,
  parameter int NUM_PRIMS  = 1024
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [PRIM_WIDTH-1:0]         rsp_data,
  output logic                          rsp_err,
  output logic                          ram_rd_en,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  input  logic [PRIM_WIDTH-1:0]         ram_rd_data,
  output logic                          busy,
  output logic [31:0]                   fetch_count
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_READ    = 2'd1;
  localparam logic [1:0] ST_RESPOND = 2'd2;

  // One extra bit so a limit of exactly 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] PRIM_LIMIT = (ADDR_WIDTH+1)'(NUM_PRIMS);
  localparam logic [GW-1:0]       LAST_INIT  = GW'(NUM_REQ - 1);

  logic [1:0]            state;
  logic [GW-1:0]         last_grant;
  logic [GW-1:0]         gnt_q;
  logic                  err_q;

  logic                  pick_found;
  logic [GW-1:0]         pick;
  logic [GW-1:0]         cand;
  logic [ADDR_WIDTH-1:0] pick_addr;
  logic                  pick_err;
  logic                  grant_now;
  logic                  rsp_done;

  // Search starts just after the previous winner, wrapping modulo NUM_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick       = last_grant;
    cand       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = GW'((int'(last_grant) + i) % NUM_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick       = cand;
      end
    end
  end

  always_comb begin
    pick_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == GW'(i)) pick_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  assign pick_err  = {1'b0, pick_addr} >= PRIM_LIMIT;
  assign grant_now = (state == ST_IDLE) && pick_found;
  assign req_ready = grant_now ? (NUM_REQ'(1) << pick) : '0;
  assign ram_rd_en = grant_now && !pick_err;
  assign ram_addr  = ram_rd_en ? pick_addr : '0;
  assign rsp_valid = (state == ST_RESPOND) ? (NUM_REQ'(1) << gnt_q) : '0;
  assign rsp_done  = (state == ST_RESPOND) && rsp_ready[gnt_q];
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      last_grant  <= LAST_INIT;
      gnt_q       <= '0;
      err_q       <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      fetch_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_now) begin
            gnt_q      <= pick;
            err_q      <= pick_err;
            last_grant <= pick;
            state      <= ST_READ;
          end
        end
        ST_READ: begin
          rsp_data <= err_q ? '0 : ram_rd_data;
          rsp_err  <= err_q;
          state    <= ST_RESPOND;
        end
        ST_RESPOND: begin
          if (rsp_done) begin
            if (fetch_count != 32'hFFFF_FFFF) fetch_count <= fetch_count + 32'd1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bvh_prim_fetch_arbiter.sv
// Bench for bvh_prim_fetch_arbiter: table of request patterns with a response scoreboard,
// plus hand-written sequences for round robin under load, backpressure and reset mid-fetch.
module tb_bvh_prim_fetch_arbiter;
  localparam int NR = 4;
  localparam int AW = 11;
  localparam int PW = 256;
  localparam int NP = 1024;

  logic             clk;
  logic             reset_n;
  logic [NR-1:0]    req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    rsp_valid;
  logic [NR-1:0]    rsp_ready;
  logic [PW-1:0]    rsp_data;
  logic             rsp_err;
  logic             ram_rd_en;
  logic [AW-1:0]    ram_addr;
  logic [PW-1:0]    ram_rd_data;
  logic             busy;
  logic [31:0]      fetch_count;

  bvh_prim_fetch_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .PRIM_WIDTH(PW), .NUM_PRIMS(NP)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_rd_data(ram_rd_data),
    .busy(busy), .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Primitive store contents: rows 0..3 are the four-voxel test scene, the rest a pattern.
  function automatic logic [PW-1:0] row_val(input logic [AW-1:0] a);
    case (a)
      11'd0: return {32'h00000010, 32'h00000020, 32'h00000030, 32'h00000110,
                     32'h00000120, 32'h00000130, 32'h00FF0000, 32'h00000000};
      11'd1: return {32'h00000140, 32'h00000020, 32'h00000030, 32'h00000240,
                     32'h00000120, 32'h00000130, 32'h0000FF00, 32'h00000001};
      11'd2: return {32'h00000010, 32'h00000150, 32'h00000030, 32'h00000110,
                     32'h00000250, 32'h00000130, 32'h000000FF, 32'h00000002};
      11'd3: return {32'hA5A5A5A5, 32'h00000150, 32'h00000160, 32'h00000240,
                     32'h00000250, 32'h00000260, 32'h00FFFFFF, 32'h00000003};
      default: return {8{5'h1B, a, 16'hC3C3}};
    endcase
  endfunction

  always @(posedge clk) if (ram_rd_en) ram_rd_data <= row_val(ram_addr);

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [NR-1:0] oh(input int g);
    logic [NR-1:0] r;
    r = '0;
    r[g] = 1'b1;
    return r;
  endfunction

  typedef struct packed {
    logic [NR-1:0]        mask;
    logic [NR-1:0][AW-1:0] addr;
    logic [NR-1:0][1:0]   order;
    logic [2:0]           n;
  } vec_t;

  typedef struct packed {
    logic [1:0]    g;
    logic [PW-1:0] data;
    logic          err;
    logic [31:0]   t;
  } sb_t;

  sb_t sb[$];
  int  model_count = 0;
  vec_t vecs[7];

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    rsp_ready = '1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    sb.delete();
    model_count = 0;
  endtask

  task automatic run_vector(input int vi, input vec_t v);
    int k;
    int n;
    int g;
    bit done;
    logic [NR-1:0] granted;
    logic [AW-1:0] a;
    logic e_err;
    sb_t e;
    k = 0; n = 0; done = 0;
    req_addr  = v.addr;
    req_valid = v.mask;
    rsp_ready = '1;
    while (!done && n < 60) begin
      @(negedge clk);
      granted = '0;
      if (req_ready != '0) begin
        if (k >= int'(v.n)) begin
          chk($sformatf("v%0d_extra_grant", vi), req_ready, '0);
        end else begin
          g = int'(v.order[k]);
          a = v.addr[g];
          e_err = (a >= 11'd1024);
          chk($sformatf("v%0d_grant%0d", vi, k), req_ready, oh(g));
          chk($sformatf("v%0d_rd_en%0d", vi, k), ram_rd_en, !e_err);
          if (!e_err) chk($sformatf("v%0d_ram_addr%0d", vi, k), ram_addr, a);
          e.g = 2'(g); e.data = e_err ? '0 : row_val(a); e.err = e_err; e.t = cyc;
          sb.push_back(e);
          k++;
        end
        granted = req_ready;
      end
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          chk($sformatf("v%0d_unexpected_rsp", vi), rsp_valid, '0);
        end else begin
          e = sb.pop_front();
          chk($sformatf("v%0d_rsp_valid", vi), rsp_valid, oh(int'(e.g)));
          chk($sformatf("v%0d_rsp_data", vi), rsp_data, e.data);
          chk($sformatf("v%0d_rsp_err", vi), rsp_err, e.err);
          chk($sformatf("v%0d_latency", vi), cyc - int'(e.t), 2);
          model_count++;
        end
      end
      @(posedge clk);
      #1 req_valid = req_valid & ~granted;
      n++;
      done = (k == int'(v.n)) && (sb.size() == 0);
    end
    if (!done) chk($sformatf("v%0d_timeout", vi), 1, 0);
    chk($sformatf("v%0d_fetch_count", vi), fetch_count, model_count);
    chk($sformatf("v%0d_busy_end", vi), busy, 0);
  endtask

  initial begin
    int gcnt;
    int last_t;
    int n;
    bit saw;
    logic [NR-1:0] exp_rr[5];

    // addr = {a3,a2,a1,a0}; order = {o3,o2,o1,o0}, o0 is the first expected grant
    vecs[0] = '{mask: 4'b0001, addr: {11'd0, 11'd0, 11'd0, 11'd3},
                order: {2'd0, 2'd0, 2'd0, 2'd0}, n: 3'd1};
    vecs[1] = '{mask: 4'b1111, addr: {11'd40, 11'd30, 11'd20, 11'd10},
                order: {2'd0, 2'd3, 2'd2, 2'd1}, n: 3'd4};
    vecs[2] = '{mask: 4'b0110, addr: {11'd0, 11'd1023, 11'd5, 11'd0},
                order: {2'd0, 2'd0, 2'd2, 2'd1}, n: 3'd2};
    vecs[3] = '{mask: 4'b1001, addr: {11'd7, 11'd0, 11'd0, 11'd1024},
                order: {2'd0, 2'd0, 2'd0, 2'd3}, n: 3'd2};
    vecs[4] = '{mask: 4'b1010, addr: {11'd2047, 11'd0, 11'd1023, 11'd0},
                order: {2'd0, 2'd0, 2'd3, 2'd1}, n: 3'd2};
    vecs[5] = '{mask: 4'b0101, addr: {11'd0, 11'd2, 11'd0, 11'd0},
                order: {2'd0, 2'd0, 2'd2, 2'd0}, n: 3'd2};
    vecs[6] = '{mask: 4'b1111, addr: {11'd3, 11'd2, 11'd1, 11'd0},
                order: {2'd2, 2'd1, 2'd0, 2'd3}, n: 3'd4};

    reset_n = 1'b0; req_valid = '0; req_addr = '0; rsp_ready = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_ram_rd_en", ram_rd_en, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_fetch_count", fetch_count, 0);
    do_reset();

    for (int i = 0; i < 7; i++) run_vector(i, vecs[i]);

    // Round robin with every requester holding its request continuously.
    do_reset();
    exp_rr[0] = 4'b0001; exp_rr[1] = 4'b0010; exp_rr[2] = 4'b0100;
    exp_rr[3] = 4'b1000; exp_rr[4] = 4'b0001;
    req_addr  = {11'd3, 11'd2, 11'd1, 11'd0};
    req_valid = 4'b1111;
    gcnt = 0; last_t = 0; n = 0;
    while (gcnt < 5 && n < 40) begin
      @(negedge clk);
      if (req_ready != '0) begin
        chk($sformatf("rr_grant%0d", gcnt), req_ready, exp_rr[gcnt]);
        if (gcnt > 0) chk($sformatf("rr_spacing%0d", gcnt), cyc - last_t, 3);
        last_t = cyc;
        gcnt++;
      end
      n++;
    end
    if (gcnt < 5) chk("rr_timeout", gcnt, 5);

    // Backpressure: response to requester 2 held while others wait.
    do_reset();
    rsp_ready = 4'b1011;
    req_addr  = {11'd0, 11'd9, 11'd2, 11'd1};
    req_valid = 4'b0100;
    @(negedge clk);
    chk("bp_grant", req_ready, 4'b0100);
    @(posedge clk);
    #1 req_valid = 4'b0011;
    @(negedge clk);
    chk("bp_read_no_ready", req_ready, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("bp_rsp_valid%0d", i), rsp_valid, 4'b0100);
      chk($sformatf("bp_rsp_data%0d", i), rsp_data, row_val(11'd9));
      chk($sformatf("bp_req_ready%0d", i), req_ready, 0);
      chk($sformatf("bp_rd_en%0d", i), ram_rd_en, 0);
    end
    @(posedge clk);
    #1 rsp_ready = 4'b1111;
    @(negedge clk);
    chk("bp_still_valid", rsp_valid, 4'b0100);
    @(negedge clk);
    chk("bp_released", rsp_valid, 0);
    chk("bp_fetch_count", fetch_count, 1);
    chk("bp_next_grant", req_ready, 4'b0001);

    // Reset asserted while the fetch is in the READ state.
    do_reset();
    req_addr  = {11'd0, 11'd0, 11'd5, 11'd4};
    req_valid = 4'b0001;
    @(negedge clk);
    chk("mid_grant", req_ready, 4'b0001);
    @(posedge clk);
    #1;
    chk("mid_busy_read", busy, 1);
    reset_n = 1'b0;
    req_valid = '0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_rd_en", ram_rd_en, 0);
    chk("mid_rst_rsp_data", rsp_data, 0);
    chk("mid_rst_rsp_err", rsp_err, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    saw = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid != '0) saw = 1;
    end
    chk("mid_no_rsp", saw, 0);
    chk("mid_fetch_count", fetch_count, 0);
    @(posedge clk);
    #1 req_valid = 4'b0011;
    @(negedge clk);
    chk("mid_first_grant", req_ready, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
